clock_div_ctrl: RTL

Programmable tick scheduler and controller for the system clock divider. It owns the divide count and produces a single-cycle `tick` clock-enable every `period` cycles, with start/stop sequencing. It also accepts runtime divisor changes over a valid/ready handshake and applies each change only at a period boundary, so no period is ever truncated or stretched. It sits between the top-level control logic and every slow-rate consumer: display scan, debounce and timers.

---
 rtl/clock_div_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable tick scheduler for the system clock divider.
// Produces a single-cycle `tick` enable every `period` cycles, with
// start/stop sequencing and valid/ready divisor updates applied only at a
// period boundary, so a running period is never truncated or stretched.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   start      level-sampled, begins counting from STOPPED
//   stop       level-sampled, halts counting (wins over start, wrap, transfer)
//   cfg_valid  new divisor offered
//   cfg_div    offered divisor (values below 2 are clamped to 2)
//   cfg_ready  divisor can be accepted (low while a reload is pending)
//   tick       registered, one cycle high per period
//   running    high while counting
//   count      current count, 0..period-1
//   period     active divisor
//   div_clock  square wave of 2*period cycles, only with
//              CLOCK_DIV_CTRL_DIV_CLOCK_EN defined
//
// State    | meaning
// ---------+---------------------------------------------------
// STOPPED  | idle, transfers write period directly
// RUN      | counting, no divisor pending
// RUN_PEND | counting, new divisor held in pend until next wrap

module clock_div_ctrl #(
  parameter int WIDTH       = 17,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] period
`ifdef CLOCK_DIV_CTRL_DIV_CLOCK_EN
  ,
  output logic             div_clock
`endif
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             wrap;
  logic             xfer;
  logic [WIDTH-1:0] cfg_clamped;

  assign wrap        = (count == period - 1'b1);
  assign xfer        = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_STOPPED;
      count     <= '0;
      tick      <= 1'b0;
      running   <= 1'b0;
      cfg_ready <= 1'b1;
      period    <= WIDTH'(DEFAULT_DIV);
      pend      <= '0;
`ifdef CLOCK_DIV_CTRL_DIV_CLOCK_EN
      div_clock <= 1'b0;
`endif
    end else begin
      case (state)
        ST_STOPPED: begin
          tick <= 1'b0;
          if (xfer) period <= cfg_clamped;
          if (start && !stop) begin
            state   <= ST_RUN;
            count   <= '0;
            running <= 1'b1;
          end
        end

        ST_RUN, ST_RUN_PEND: begin
          if (stop) begin
            // Stop beats a same-edge wrap and transfer; a pending divisor
            // is not lost, it becomes the stopped period.
            state     <= ST_STOPPED;
            count     <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            cfg_ready <= 1'b1;
            if (state == ST_RUN_PEND) period <= pend;
`ifdef CLOCK_DIV_CTRL_DIV_CLOCK_EN
            div_clock <= 1'b0;
`endif
          end else begin
            if (wrap) begin
              count <= '0;
              tick  <= 1'b1;
`ifdef CLOCK_DIV_CTRL_DIV_CLOCK_EN
              div_clock <= ~div_clock;
`endif
            end else begin
              count <= count + 1'b1;
              tick  <= 1'b0;
            end

            if (state == ST_RUN) begin
              // A transfer on a wrap edge still waits for the next wrap.
              if (xfer) begin
                pend      <= cfg_clamped;
                state     <= ST_RUN_PEND;
                cfg_ready <= 1'b0;
              end
            end else if (wrap) begin
              period    <= pend;
              state     <= ST_RUN;
              cfg_ready <= 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_STOPPED;
          count     <= '0;
          tick      <= 1'b0;
          running   <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
